text_cycler: RTL and testbench

- Parametrised successor to the fixed four-word text sequencer.
- Cycles through NUM_WORDS words of CHARS glyphs each. Every word fades in, holds, fades out, then the next word starts.
- Sits in the video path beside the munch pattern.
- Outputs a registered glyph pixel plus a 3-bit intensity level. The mixer combines these with the munch level.

---
 rtl/video_pkg.sv | 21 ++
 rtl/seg_glyph.sv | 35 +++
 rtl/text_cycler.sv | 113 +++++++++++
 tb/tb_text_cycler.sv | 139 +++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: glyph codes, 10-segment map, glyph cell geometry and text fade FSM states
package video_pkg;
  typedef enum logic [1:0] {FADE_IN, HOLD, FADE_OUT} state_t;
  localparam logic [3:0] C_SP = 4'd0, C_A = 4'd1, C_C = 4'd2, C_E = 4'd3, C_H = 4'd4, C_K = 4'd5;
  localparam logic [3:0] C_L = 4'd6, C_P = 4'd7, C_R = 4'd8, C_S = 4'd9, C_T = 4'd10, C_V = 4'd11;
  localparam int GW = 50, GH = 100, GHH = 50, GC = 25, GT = 6;
  // bit i lights segment i: top, UR, LR, bottom, LL, UL, middle, upper diag, lower diag, centre vertical
  function automatic logic [9:0] seg_map(input logic [3:0] code);
    return code == C_A ? 10'h077 :
           code == C_C ? 10'h039 :
           code == C_E ? 10'h079 :
           code == C_H ? 10'h076 :
           code == C_K ? 10'h1b0 :
           code == C_L ? 10'h038 :
           code == C_P ? 10'h073 :
           code == C_R ? 10'h173 :
           code == C_S ? 10'h06d :
           code == C_T ? 10'h201 :
           code == C_V ? 10'h122 : 10'h000;
  endfunction
endpackage

// File: rtl/seg_glyph.sv
// seg_glyph: combinational 10-segment glyph renderer for one 50x100 cell at origin (x_i, y_i)
module seg_glyph
  import video_pkg::*;
(
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  input  logic [3:0] code_i,
  input  logic [9:0] hpos_i,
  input  logic [9:0] vpos_i,
  output logic       pixel_o
);
  localparam logic [9:0] W = 10'(GW), H = 10'(GH), HH = 10'(GHH), C = 10'(GC), T = 10'(GT);
  localparam logic [10:0] H2 = 11'(GH), T2 = 11'(GT);
  logic [9:0] lx, ly, s;
  logic [10:0] u, v, ly2;
  logic in_cell;
  assign lx = hpos_i - x_i;
  assign ly = vpos_i - y_i;
  assign in_cell = hpos_i >= x_i && vpos_i >= y_i && lx < W && ly < H;
  assign u = {lx, 1'b0} + {1'b0, ly};
  assign v = {lx, 1'b0};
  assign ly2 = {1'b0, ly};
  assign s[0] = ly < T;
  assign s[1] = lx >= W - T && ly < HH;
  assign s[2] = lx >= W - T && ly >= HH;
  assign s[3] = ly >= H - T;
  assign s[4] = lx < T && ly >= HH;
  assign s[5] = lx < T && ly < HH;
  assign s[6] = ly >= HH - T / 2 && ly < HH + T / 2;
  // diagonals run from the cell centre to the top-right and bottom-right corners
  assign s[7] = ly < HH && u + T2 >= H2 && u <= H2 + T2;
  assign s[8] = ly >= HH && v + T2 >= ly2 && v <= ly2 + T2;
  assign s[9] = lx >= C - T / 2 && lx < C + T / 2;
  assign pixel_o = in_cell && |(s & seg_map(code_i));
endmodule

// File: rtl/text_cycler.sv
// text_cycler: cycles NUM_WORDS words through fade-in/hold/fade-out, rendering glyph pixels and level.
// Optional TEXT_CYCLER_BLINK_EN blanks the pixel 16 of every 32 frames while holding.
module text_cycler
  import video_pkg::*;
#(
  parameter int NUM_WORDS        = 4,
  parameter int CHARS            = 6,
  parameter int CHAR_PITCH       = 64,
  parameter int X0               = 100,
  parameter int Y0               = 280,
  parameter int FADE_STEP_FRAMES = 4,
  parameter int HOLD_FRAMES      = 60
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [9:0]                       hpos,
  input  logic [9:0]                       vpos,
  input  logic                             frame_tick,
  input  logic                             pause,
  input  logic [NUM_WORDS*CHARS*4-1:0]     words,
  output logic                             pixel,
  output logic [2:0]                       level,
  output logic [$clog2(NUM_WORDS)-1:0]     word_idx
);
  localparam int LP = $clog2(CHAR_PITCH);
  localparam int WW = $clog2(NUM_WORDS);
  localparam int CW = $clog2((FADE_STEP_FRAMES > HOLD_FRAMES ? FADE_STEP_FRAMES : HOLD_FRAMES) + 1);
  localparam logic [9:0] XL = 10'(X0), XR = 10'(X0 + CHARS * CHAR_PITCH), YT = 10'(Y0);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] level_q, level_d;
  logic [WW-1:0] word_q, word_d;
  logic pixel_q, pixel_d;
  logic tick, step_done, hold_done, in_region, hit, blank;
  logic [9:0] dx, ci, gx;
  logic [3:0] code;
  assign tick = frame_tick && !pause;
  assign step_done = cnt_q == CW'(FADE_STEP_FRAMES - 1);
  assign hold_done = cnt_q == CW'(HOLD_FRAMES - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    level_d = level_q;
    word_d = word_q;
    if (tick) begin
      case (state_q)
        FADE_IN: begin
          cnt_d = step_done ? '0 : cnt_q + CW'(1);
          if (step_done) begin
            level_d = level_q == 3'd7 ? level_q : level_q + 3'd1;
            state_d = level_q >= 3'd6 ? HOLD : FADE_IN;
          end
        end
        HOLD: begin
          cnt_d = hold_done ? '0 : cnt_q + CW'(1);
          state_d = hold_done ? FADE_OUT : HOLD;
        end
        FADE_OUT: begin
          cnt_d = step_done ? '0 : cnt_q + CW'(1);
          if (step_done) begin
            level_d = level_q == 3'd0 ? level_q : level_q - 3'd1;
            if (level_q <= 3'd1) begin
              state_d = FADE_IN;
              word_d = word_q == WW'(NUM_WORDS - 1) ? '0 : word_q + WW'(1);
            end
          end
        end
        default: state_d = FADE_IN;
      endcase
    end
  end
  // CHAR_PITCH is a power of two, so glyph index and origin are shifts
  assign in_region = hpos >= XL && hpos < XR;
  assign dx = hpos - XL;
  assign ci = dx >> LP;
  assign gx = XL + (ci << LP);
  assign code = in_region ? words[(int'(word_q) * CHARS + int'(ci)) * 4 +: 4] : C_SP;
  seg_glyph u_glyph (
    .x_i    (gx),
    .y_i    (YT),
    .code_i (code),
    .hpos_i (hpos),
    .vpos_i (vpos),
    .pixel_o(hit)
  );
`ifdef TEXT_CYCLER_BLINK_EN
  logic [4:0] blink_q, blink_d;
  assign blink_d = !tick ? blink_q : state_q == HOLD ? blink_q + 5'd1 : state_d == HOLD ? 5'd0 : blink_q;
  assign blank = state_q == HOLD && blink_q[4];
  always_ff @(posedge clk) blink_q <= !rst_n ? 5'd0 : blink_d;
`else
  assign blank = 1'b0;
`endif
  assign pixel_d = hit && level_q != 3'd0 && !blank;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FADE_IN;
      cnt_q <= '0;
      level_q <= '0;
      word_q <= '0;
      pixel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      word_q <= word_d;
      pixel_q <= pixel_d;
    end
  end
  assign pixel = pixel_q;
  assign level = level_q;
  assign word_idx = word_q;
endmodule

// File: tb/tb_text_cycler.sv
// tb_text_cycler: self-checking bench for text_cycler (default build, TEXT_CYCLER_BLINK_EN undefined)
module tb_text_cycler;
  localparam int NW = 4, CH = 6, FS = 1, HF = 3;
  localparam int L = 14 * FS + HF;
  logic clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, pause = 1'b0, pixel;
  logic [9:0] hpos = 10'd100, vpos = 10'd280;
  logic [NW*CH*4-1:0] words;
  logic [2:0] level;
  logic [1:0] word_idx;
  int checks = 0, errors = 0, n = 0;
  typedef struct {int h; int v; int exp; string nm;} vec_t;
  vec_t tbl[$];

  text_cycler #(.NUM_WORDS(NW), .CHARS(CH), .FADE_STEP_FRAMES(FS), .HOLD_FRAMES(HF)) dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .frame_tick(frame_tick),
    .pause(pause), .words(words), .pixel(pixel), .level(level), .word_idx(word_idx)
  );

  always #5 clk = ~clk;

  function automatic int mlevel(int cnt);
    int k = cnt % L;
    if (k < 7 * FS) return k / FS;
    if (k < 7 * FS + HF) return 7;
    return 7 - (k - 7 * FS - HF) / FS;
  endfunction

  function automatic int mword(int cnt);
    return (cnt / L) % NW;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic p);
    frame_tick = t;
    pause = p;
    @(negedge clk);
    if (!rst_n) n = 0;
    else if (t && !p) n++;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_level"}, 32'(level), 32'(mlevel(n)));
    chk({nm, "_word"}, 32'(word_idx), 32'(mword(n)));
  endtask

  initial begin
    words = {$urandom, $urandom, $urandom};
    words[23:0] = 24'h000a13;
    tbl.push_back('{100, 280, 1, "e_top"});
    tbl.push_back('{125, 305, 0, "e_inner"});
    tbl.push_back('{125, 330, 1, "e_middle"});
    tbl.push_back('{100, 330, 1, "e_lower_left"});
    tbl.push_back('{149, 280, 1, "e_top_edge"});
    tbl.push_back('{150, 280, 0, "cell_gap"});
    tbl.push_back('{164, 280, 1, "a_top"});
    tbl.push_back('{189, 379, 0, "a_no_bottom"});
    tbl.push_back('{228, 280, 1, "t_top"});
    tbl.push_back('{253, 330, 1, "t_centre"});
    tbl.push_back('{228, 330, 0, "t_side"});
    tbl.push_back('{292, 280, 0, "space_char"});
    tbl.push_back('{420, 280, 0, "last_space"});
    tbl.push_back('{99, 280, 0, "left_of_text"});
    tbl.push_back('{485, 280, 0, "right_of_text"});
    tbl.push_back('{100, 279, 0, "above_text"});
    tbl.push_back('{100, 380, 0, "below_text"});

    cyc(1, 0);
    cyc(1, 0);
    chk("rst_pixel", 32'(pixel), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_word", 32'(word_idx), 0);
    rst_n = 1'b1;
    cyc(1, 0);
    chk("first_tick_level", 32'(level), 1);
    chk("gate_level0_pixel", 32'(pixel), 0);
    cyc(0, 0);
    chk("level1_pixel", 32'(pixel), 1);

    repeat (3) cyc(1, 0);
    chk("pre_pause_level", 32'(level), 4);
    repeat (10) cyc(1, 1);
    chk("pause_level", 32'(level), 4);
    chk("pause_word", 32'(word_idx), 0);
    cyc(1, 0);
    chk("post_pause_level", 32'(level), 5);
    repeat (2) cyc(1, 0);
    chk("hold_level", 32'(level), 7);

    foreach (tbl[i]) begin
      hpos = 10'(tbl[i].h);
      vpos = 10'(tbl[i].v);
      cyc(0, 0);
      chk(tbl[i].nm, 32'(pixel), 32'(tbl[i].exp));
    end
    words[3:0] = 4'd0;
    hpos = 10'd100;
    vpos = 10'd280;
    cyc(0, 0);
    chk("words_live_update", 32'(pixel), 0);
    words[3:0] = 4'd3;
    cyc(0, 0);
    chk("words_restore", 32'(pixel), 1);

    while (n < 4 * L) begin
      cyc(1, 0);
      chk_model("cycle");
      if (n == L) chk("first_word_advance", 32'(word_idx), 1);
    end
    chk("wrap_word", 32'(word_idx), 0);
    chk("wrap_level", 32'(level), 0);

    for (int i = 0; i < 1500; i++) begin
      hpos = 10'($urandom_range(0, 639));
      vpos = 10'($urandom_range(0, 479));
      if (i % 97 == 0) words = {$urandom, $urandom, $urandom};
      if (i == 700) begin
        rst_n = 1'b0;
        cyc(1, 0);
        chk("midrun_rst_level", 32'(level), 0);
        chk("midrun_rst_word", 32'(word_idx), 0);
        chk("midrun_rst_pixel", 32'(pixel), 0);
        rst_n = 1'b1;
      end else begin
        cyc(1'($urandom % 2), 1'($urandom % 4 == 0));
        chk_model("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
